// File: rtl/arp_sequencer.sv
// rtl/arp_sequencer.sv - arpeggiator between the note registers and voice0 F_in/key_on
// Define ARP_UPDOWN_EN to build the ping-pong step order instead of the up-only wrap.
module arp_sequencer #(
   parameter int TICK_DIV  = 50000,
   parameter int GAP_TICKS = 1
) (
   input  logic        Clk,
   input  logic        Reset,
   input  logic        arp_en,
   input  logic [15:0] arp_time,
   input  logic [6:0]  freq_in0,
   input  logic [6:0]  freq_in1,
   input  logic [6:0]  freq_in2,
   input  logic [6:0]  freq_in3,
   input  logic        key_in0,
   input  logic        key_in1,
   input  logic        key_in2,
   input  logic        key_in3,
   output logic [6:0]  freq_out,
   output logic        key_out,
   output logic [1:0]  cur_idx,
   output logic        step_strobe
);
   localparam int PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;

   typedef enum logic [1:0] {IDLE, PLAY, GAP} state_t;

   state_t        r_state;
   logic [PW-1:0] r_presc;
   logic [15:0]   r_ticks;
   logic [6:0]    r_freq;
   logic          r_key;
   logic [1:0]    r_idx;
   logic          r_strobe;
`ifdef ARP_UPDOWN_EN
   logic          r_dir_down;
`endif

   logic [3:0]    w_held;
   logic [6:0]    w_freq_sel [4];
   logic          w_tick;
   logic [16:0]   w_cnt_next;
   logic [16:0]   w_step_len;
   logic          w_step_done;
   logic          w_gap_done;
   logic [1:0]    w_first_idx;
   logic [1:0]    w_next_idx;
   logic          w_enter;
   logic [1:0]    w_enter_idx;

   assign w_held        = {key_in3, key_in2, key_in1, key_in0};
   assign w_freq_sel[0] = freq_in0;
   assign w_freq_sel[1] = freq_in1;
   assign w_freq_sel[2] = freq_in2;
   assign w_freq_sel[3] = freq_in3;

   assign w_tick      = (r_presc == PW'(TICK_DIV - 1));
   assign w_cnt_next  = {1'b0, r_ticks} + {16'd0, w_tick};
   // arp_time is compared live so a shortened step ends at once
   assign w_step_len  = (arp_time == 16'd0) ? 17'd1 : {1'b0, arp_time};
   assign w_step_done = (w_cnt_next >= w_step_len);
   assign w_gap_done  = (w_cnt_next >= 17'(GAP_TICKS));

   always_comb begin
      w_first_idx = 2'd0;
      for (int i = 3; i >= 0; i--)
         if (w_held[2'(i)]) w_first_idx = 2'(i);
   end

`ifdef ARP_UPDOWN_EN
   logic       w_has_up;
   logic       w_has_dn;
   logic [1:0] w_up_idx;
   logic [1:0] w_dn_idx;
   logic       w_next_down;

   always_comb begin
      w_has_up    = 1'b0;
      w_has_dn    = 1'b0;
      w_up_idx    = r_idx;
      w_dn_idx    = r_idx;
      for (int i = 3; i >= 0; i--)
         if (i > int'(r_idx) && w_held[2'(i)]) begin
            w_has_up = 1'b1;
            w_up_idx = 2'(i);
         end
      for (int i = 0; i < 4; i++)
         if (i < int'(r_idx) && w_held[2'(i)]) begin
            w_has_dn = 1'b1;
            w_dn_idx = 2'(i);
         end
      w_next_idx  = r_idx;
      w_next_down = r_dir_down;
      if (!r_dir_down) begin
         if (w_has_up) w_next_idx = w_up_idx;
         else if (w_has_dn) begin
            w_next_idx  = w_dn_idx;
            w_next_down = 1'b1;
         end
      end else begin
         if (w_has_dn) w_next_idx = w_dn_idx;
         else if (w_has_up) begin
            w_next_idx  = w_up_idx;
            w_next_down = 1'b0;
         end
      end
   end
`else
   // Nearest held index after r_idx wins; falls back to repeating r_idx
   always_comb begin
      w_next_idx = r_idx;
      for (int i = 3; i >= 1; i--)
         if (w_held[2'(int'(r_idx) + i)]) w_next_idx = 2'(int'(r_idx) + i);
   end
`endif

   always_comb begin
      w_enter     = 1'b0;
      w_enter_idx = w_next_idx;
      if (arp_en && (w_held != 4'd0)) begin
         case (r_state)
            IDLE: begin
               w_enter     = 1'b1;
               w_enter_idx = w_first_idx;
            end
            PLAY:    w_enter = w_step_done && (GAP_TICKS == 0);
            GAP:     w_enter = w_gap_done;
            default: w_enter = 1'b0;
         endcase
      end
   end

   always_ff @(posedge Clk) begin
      if (Reset) begin
         r_state  <= IDLE;
         r_presc  <= '0;
         r_ticks  <= '0;
         r_freq   <= '0;
         r_key    <= 1'b0;
         r_idx    <= 2'd0;
         r_strobe <= 1'b0;
`ifdef ARP_UPDOWN_EN
         r_dir_down <= 1'b0;
`endif
      end else if (!arp_en) begin
         r_state  <= IDLE;
         r_presc  <= w_tick ? '0 : r_presc + 1'b1;
         r_freq   <= freq_in0;
         r_key    <= key_in0;
         r_idx    <= 2'd0;
         r_strobe <= 1'b0;
      end else begin
         r_presc  <= (w_tick || w_enter) ? '0 : r_presc + 1'b1;
         r_strobe <= w_enter;
         if (w_enter) begin
            r_state <= PLAY;
            r_key   <= 1'b1;
            r_idx   <= w_enter_idx;
            r_freq  <= w_freq_sel[w_enter_idx];
            r_ticks <= '0;
`ifdef ARP_UPDOWN_EN
            r_dir_down <= (r_state == IDLE) ? 1'b0 : w_next_down;
`endif
         end else begin
            case (r_state)
               IDLE: r_key <= 1'b0;
               PLAY: begin
                  if (w_held == 4'd0) begin
                     r_state <= IDLE;
                     r_key   <= 1'b0;
                  end else if (w_step_done) begin
                     r_state <= GAP;
                     r_key   <= 1'b0;
                     r_ticks <= '0;
                  end else begin
                     r_ticks <= w_cnt_next[15:0];
                  end
               end
               GAP: begin
                  if (w_held == 4'd0) begin
                     r_state <= IDLE;
                     r_key   <= 1'b0;
                  end else begin
                     r_ticks <= w_cnt_next[15:0];
                  end
               end
               default: r_state <= IDLE;
            endcase
         end
      end
   end

   assign freq_out    = r_freq;
   assign key_out     = r_key;
   assign cur_idx     = r_idx;
   assign step_strobe = r_strobe;
endmodule

// File: tb/tb_arp_sequencer.sv
// tb/tb_arp_sequencer.sv - scoreboard bench for arp_sequencer (gap and no-gap builds)
// Reference model derives step timing from elapsed cycles since each step start.
module tb_arp_sequencer;
   localparam int TD = 4;

   logic        clk;
   logic        rst;
   logic        en;
   logic [15:0] at;
   logic [6:0]  fin [4];
   logic [3:0]  keys;

   logic [6:0]  fo_a, fo_b;
   logic        ko_a, ko_b;
   logic [1:0]  io_a, io_b;
   logic        so_a, so_b;

   arp_sequencer #(.TICK_DIV(TD), .GAP_TICKS(1)) dut_a (
      .Clk(clk), .Reset(rst), .arp_en(en), .arp_time(at),
      .freq_in0(fin[0]), .freq_in1(fin[1]), .freq_in2(fin[2]), .freq_in3(fin[3]),
      .key_in0(keys[0]), .key_in1(keys[1]), .key_in2(keys[2]), .key_in3(keys[3]),
      .freq_out(fo_a), .key_out(ko_a), .cur_idx(io_a), .step_strobe(so_a)
   );

   arp_sequencer #(.TICK_DIV(TD), .GAP_TICKS(0)) dut_b (
      .Clk(clk), .Reset(rst), .arp_en(en), .arp_time(at),
      .freq_in0(fin[0]), .freq_in1(fin[1]), .freq_in2(fin[2]), .freq_in3(fin[3]),
      .key_in0(keys[0]), .key_in1(keys[1]), .key_in2(keys[2]), .key_in3(keys[3]),
      .freq_out(fo_b), .key_out(ko_b), .cur_idx(io_b), .step_strobe(so_b)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      int mode;        // 0 idle, 1 sounding step, 2 silent gap
      int cyc;
      int play_start;
      int gap_base;
      int idx;
      int freq;
      int key;
      int strobe;
      int down;
   } model_t;

   model_t      m_a, m_b;
   logic [10:0] q_a [$];
   logic [10:0] q_b [$];
   int          n_checks = 0;
   int          n_pass   = 0;

   function automatic int pick_next(int cur, int down, output int new_down);
      int r;
      r = cur;
      new_down = down;
`ifdef ARP_UPDOWN_EN
      begin
         int up_c, dn_c;
         up_c = -1;
         dn_c = -1;
         for (int j = 3; j > cur; j--) if (keys[j]) up_c = j;
         for (int j = 0; j < cur; j++) if (keys[j]) dn_c = j;
         if (down == 0) begin
            if (up_c >= 0) r = up_c;
            else if (dn_c >= 0) begin r = dn_c; new_down = 1; end
         end else begin
            if (dn_c >= 0) r = dn_c;
            else if (up_c >= 0) begin r = up_c; new_down = 0; end
         end
      end
`else
      for (int k = 3; k >= 1; k--) if (keys[(cur + k) % 4]) r = (cur + k) % 4;
`endif
      return r;
   endfunction

   function automatic model_t start_step(model_t s, int i, int down);
      model_t n;
      n            = s;
      n.mode       = 1;
      n.key        = 1;
      n.strobe     = 1;
      n.idx        = i;
      n.freq       = int'(fin[i]);
      n.play_start = s.cyc + 1;
      n.down       = down;
      return n;
   endfunction

   function automatic model_t mstep(model_t s, int gap);
      model_t n;
      int     el, len, nd, nx, lo;
      n        = s;
      n.cyc    = s.cyc + 1;
      n.strobe = 0;
      el  = (s.cyc - s.play_start + 1) / TD;
      len = (at == 16'd0) ? 1 : int'(at);
      if (rst) begin
         n.mode = 0; n.play_start = 0; n.gap_base = 0; n.idx = 0;
         n.freq = 0; n.key = 0; n.down = 0;
      end else if (!en) begin
         n.mode = 0; n.freq = int'(fin[0]); n.key = int'(keys[0]); n.idx = 0;
      end else if (s.mode == 0) begin
         n.key = 0;
         if (keys != 4'd0) begin
            lo = 0;
            for (int j = 3; j >= 0; j--) if (keys[j]) lo = j;
            n = start_step(s, lo, 0);
            n.cyc = s.cyc + 1;
         end
      end else if (keys == 4'd0) begin
         n.mode = 0; n.key = 0;
      end else if ((s.mode == 1 && el >= len && gap == 0) ||
                   (s.mode == 2 && el - s.gap_base >= gap)) begin
         nx = pick_next(s.idx, s.down, nd);
         n = start_step(s, nx, nd);
         n.cyc = s.cyc + 1;
      end else if (s.mode == 1 && el >= len) begin
         n.mode = 2; n.key = 0; n.gap_base = el;
      end
      return n;
   endfunction

   function automatic logic [10:0] pack(model_t m);
      return {7'(m.freq), 1'(m.key), 2'(m.idx), 1'(m.strobe)};
   endfunction

   task automatic run(int n);
      for (int c = 0; c < n; c++) begin
         m_a = mstep(m_a, 1);
         m_b = mstep(m_b, 0);
         q_a.push_back(pack(m_a));
         q_b.push_back(pack(m_b));
         @(negedge clk);
      end
   endtask

   task automatic check_one(string name, logic [10:0] got, logic [10:0] exp);
      n_checks++;
      if (got === exp) n_pass++;
      else $display("FAIL %s t=%0t got freq=%0d key=%0d idx=%0d strobe=%0d want freq=%0d key=%0d idx=%0d strobe=%0d",
                    name, $time, got[10:4], got[3], got[2:1], got[0], exp[10:4], exp[3], exp[2:1], exp[0]);
   endtask

   // Monitor: every cycle the DUTs present an output word; pop and compare
   initial begin
      forever begin
         @(posedge clk);
         #1;
         if (q_a.size() > 0) check_one("gap1", {fo_a, ko_a, io_a, so_a}, q_a.pop_front());
         if (q_b.size() > 0) check_one("gap0", {fo_b, ko_b, io_b, so_b}, q_b.pop_front());
      end
   end

   initial begin
      m_a = '{0, 0, 0, 0, 0, 0, 0, 0, 0};
      m_b = '{0, 0, 0, 0, 0, 0, 0, 0, 0};
      rst = 1'b1; en = 1'b0; at = 16'd2; keys = 4'd0;
      for (int i = 0; i < 4; i++) fin[i] = 7'd0;
      run(3);
      rst = 1'b0;
      run(2);
      fin[0] = 7'd60; keys = 4'b0001;
      run(3);
      keys = 4'b0000;
      run(3);
      fin[0] = 7'd48; fin[2] = 7'd55; keys = 4'b0101; en = 1'b1; at = 16'd2;
      run(40);
      keys = 4'b0000;
      run(3);
      fin[1] = 7'd50; keys = 4'b0010;
      run(12);
      at = 16'd0; keys = 4'b1011;
      run(20);
      keys = 4'b1000; fin[3] = 7'd72;
      run(20);
      en = 1'b0;
      run(2);
      at = 16'd2; keys = 4'b0101; en = 1'b1;
      run(3);
      fin[0] = 7'd40;
      run(30);
      at = 16'd5;
      run(6);
      at = 16'd1;
      run(4);
      en = 1'b0;
      run(3);
      en = 1'b1; keys = 4'b1011;
      run(40);
      rst = 1'b1;
      run(1);
      rst = 1'b0;
      run(20);
      for (int c = 0; c < 3000; c++) begin
         if ($urandom_range(7) == 0) keys = 4'($urandom_range(15));
         if ($urandom_range(15) == 0) fin[$urandom_range(3)] = 7'($urandom_range(127));
         if ($urandom_range(31) == 0) at = 16'($urandom_range(4));
         if ($urandom_range(63) == 0) en = ~en;
         rst = ($urandom_range(199) == 0);
         run(1);
      end
      rst = 1'b0;
      run(2);
      @(posedge clk);
      #2;
      n_checks++;
      if (q_a.size() == 0 && q_b.size() == 0) n_pass++;
      else $display("FAIL drain got %0d/%0d entries left want 0/0", q_a.size(), q_b.size());
      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end
endmodule

// File: doc/arp_sequencer.md
Name: arp_sequencer

Overview:
- Arpeggiator placed between the Nios register block and voice0.
- Consumes the four per-voice note registers (freq/key pairs) plus the arp enable and arp step-time registers.
- Produces a single freq/key_on pair for voice0's F_in/key_on inputs.
- When disabled it is a registered pass-through of note 0. When enabled it steps through held notes in turn, each for a programmable time, and retriggers the envelope at every step.

Parameters:
- TICK_DIV, 50000, Clk cycles per time tick (1 ms at 50 MHz); simulation uses 4.
- GAP_TICKS, 1, ticks key_out is held low between steps for retrigger; 0 = no gap.

Ports:
- Clk  in  1  system clock (CLOCK_50 domain)
- Reset  in  1  synchronous, active-high
- arp_en  in  1  arpeggiator enable (ARP_EN register)
- arp_time  in  16  step length in ticks (ARP_TIME register); 0 treated as 1
- freq_in0..freq_in3  in  7 each  note numbers (FREQ0..3)
- key_in0..key_in3  in  1 each  note held flags (KEY0..3)
- freq_out  out  7  note to voice0 F_in
- key_out  out  1  gate to voice0 key_on
- cur_idx  out  2  index of the note currently sounding
- step_strobe  out  1  one-cycle pulse on the cycle key_out rises at a step start

Behaviour:
- Reset values (all outputs, all state): freq_out=0, key_out=0, cur_idx=0, step_strobe=0, state=IDLE, prescaler=0, tick counter=0.
- Prescaler: counts 0..TICK_DIV-1. It produces a tick on the cycle it wraps and is cleared on every transition into PLAY.
- Pass-through (arp_en=0):
  - freq_out<=freq_in0, key_out<=key_in0, with 1-cycle latency.
  - cur_idx=0, step_strobe=0; the FSM is forced to IDLE.
- FSM (arp_en=1), states IDLE, PLAY, GAP. "held" = {key_in3..key_in0}.
- IDLE:
  - key_out=0.
  - If held!=0, the next cycle enters PLAY with the lowest set index.
- Entering PLAY (next cycle):
  - key_out=1, freq_out latched from freq_in[idx], cur_idx=idx, step_strobe=1 for that cycle.
  - Tick counter and prescaler cleared.
- PLAY:
  - freq_out holds its latched value; mid-step freq_in changes are ignored.
  - After max(arp_time,1) ticks, go to GAP if GAP_TICKS>0, otherwise directly to the next step.
- GAP:
  - key_out=0, freq_out held.
  - After GAP_TICKS ticks, advance to the next step.
- Next-step selection: the first held index strictly after cur_idx, wrapping 3->0.
  - If only cur_idx is held, repeat the same note.
  - The search uses held sampled on the advance cycle.
- All keys released (held==0) in PLAY or GAP:
  - IDLE and key_out=0 on the next cycle, overriding any pending timer event.
  - freq_out keeps its last value.
- Current note released while other notes are held: the step runs to completion and the note keeps sounding.
- arp_time changes mid-step take effect at the comparison immediately (counter >= new value ends the step).
- arp_en 1->0: pass-through from the next cycle. arp_en 0->1: starts from IDLE.
- Simultaneous step end and arp_en fall: arp_en wins.
- Reset asserted at any time overrides everything and gives reset values next cycle.

Optional Feature:
- Macro ARP_UPDOWN_EN.
- When defined:
  - Adds an internal direction flag (reset = up) and produces a ping-pong pattern.
  - Up: next held index above cur_idx. Down: next held index below.
  - When no held index exists in the current direction, flip direction and take the nearest held index in the new direction.
  - With one note held, repeat it.
  - Entering PLAY from IDLE resets direction to up.
- When undefined: up-only wrap pattern as above; no direction state is synthesised.

Test Plan:
- Pass-through: arp_en=0, freq_in0=60, key_in0=1 -> freq_out=60, key_out=1 one cycle later; key_in0=0 -> key_out=0 one cycle later.
- Basic cycle: TICK_DIV=4, GAP_TICKS=1, arp_time=2; keys 0,2 held with freq 48,55 -> sequence 48 (8 cycles high), 4 cycles low, 55, gap, 48...; step_strobe once per step; cur_idx 0,2,0.
- Release handling: during the note-2 step release all keys -> key_out=0 and state IDLE on the next cycle; re-press key1 (freq 50) -> PLAY with freq_out=50 one cycle later.
- Boundaries: arp_time=0 -> 1-tick steps. Single key3 held -> note 3 retriggered each step. GAP_TICKS=0 -> key_out stays high and freq_out changes on the step boundary.
- Mid-step changes: change freq_in0 from 48 to 40 during its PLAY -> freq_out stays 48 until the next selection of index 0, then 40. Toggle arp_en low mid-step -> pass-through next cycle.
- ARP_UPDOWN_EN (if built): keys 0,1,3 held -> index order 0,1,3,1,0,1,3; Reset mid-sequence -> all outputs 0 next cycle, restarts up from index 0.
